// File: rtl/upscale_pixel_feeder.sv
// Pixel feeder for the upscaler: buffers upstream RGB888 pixels in a small FIFO and replays
// each one for three valid cycles. Optional FEEDER_STALL_CNT_EN adds a stall_count output.
module upscale_pixel_feeder #(
    parameter int IMG_W      = 384,
    parameter int IMG_H      = 216,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [23:0]               s_pixel,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      start,
    output logic [23:0]               pixel_out,
    output logic                      pixel_valid,
    output logic [1:0]                phase,
    output logic [$clog2(IMG_W)-1:0]  col,
    output logic [$clog2(IMG_H)-1:0]  row,
    output logic                      busy,
    output logic                      frame_done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]               stall_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
    state_t state;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, last_px, fifo_ne;

    // Readiness comes from the registered count only, so a full FIFO refuses
    // a push even in a cycle where it is also popped.
    assign s_ready = !rst && (count < (AW+1)'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign fifo_ne = (count != '0);
    assign last_px = (col == CW'(IMG_W-1)) && (row == RW'(IMG_H-1));

    always_comb begin
        pop = 1'b0;
        case (state)
            LOAD:    pop = fifo_ne;
            SEND:    pop = (phase == 2'd2) && !last_px && fifo_ne;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            phase       <= '0;
            col         <= '0;
            row         <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                LOAD: begin
                    if (fifo_ne) begin
                        pixel_out   <= mem[rd_ptr];
                        pixel_valid <= 1'b1;
                        phase       <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (phase != 2'd2) begin
                        phase <= phase + 2'd1;
                    end else if (last_px) begin
                        pixel_valid <= 1'b0;
                        phase       <= '0;
                        frame_done  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        // Advance to the next pixel; chain straight into its burst if data is waiting.
                        if (col == CW'(IMG_W-1)) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        phase <= '0;
                        if (fifo_ne) begin
                            pixel_out <= mem[rd_ptr];
                        end else begin
                            pixel_valid <= 1'b0;
                            state       <= LOAD;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (state == IDLE && start)
            stall_count <= '0;
        else if (state == LOAD && stall_count != '1)
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_upscale_pixel_feeder.sv
// Randomized bench for upscale_pixel_feeder: scoreboard of accepted pixels, each expected
// three times in order with col/row derived from its position in the frame.
module tb_upscale_pixel_feeder;
    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;
    localparam int NV = 3 * W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] s_pixel = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        start = 1'b0;
    logic [23:0] pixel_out;
    logic        pixel_valid;
    logic [1:0]  phase;
    logic [1:0]  col;
    logic        row;
    logic        busy;
    logic        frame_done;
`ifdef FEEDER_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    upscale_pixel_feeder #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .start(start), .pixel_out(pixel_out), .pixel_valid(pixel_valid), .phase(phase),
        .col(col), .row(row), .busy(busy), .frame_done(frame_done)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // upstream source
    logic [23:0] src_q[$];
    int  feed_gap = 0;
    bit  rnd_gap = 0;
    int  gap_cnt = 0;
    bit  hs = 0;

    always begin
        @(posedge clk);
        #2;
        if (hs && src_q.size() > 0) begin
            void'(src_q.pop_front());
            gap_cnt = rnd_gap ? int'($urandom_range(0, 5)) : feed_gap;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        if (src_q.size() > 0 && gap_cnt == 0) begin
            s_valid = 1'b1;
            s_pixel = src_q[0];
        end else begin
            s_valid = 1'b0;
        end
    end

    // reference model: every accepted pixel, in order, replayed three times per frame slot
    logic [23:0] sb_q[$];
    int  vcnt = 0;
    int  idx;
    int  stall_m = 0;
    bit  active = 0;
    bit  exp_fd = 0;
    bit  prev_v = 0;
    int  prev_ph = 0;
    bit  strict = 0;

    always @(negedge clk) begin
        hs = s_valid && s_ready;
        if (rst) begin
            sb_q.delete();
            vcnt = 0; active = 0; exp_fd = 0; prev_v = 0; prev_ph = 0; stall_m = 0;
        end else begin
            chk("busy", 32'(busy), 32'(active));
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
            exp_fd = 0;
            if (prev_v && prev_ph != 2) chk("burst_gap", 32'(pixel_valid), 32'd1);
            if (pixel_valid) begin
                idx = vcnt / 3;
                if (sb_q.size() == 0) chk("underrun", 32'(pixel_out), 32'hFFFF_FFFF);
                else chk("pixel", 32'(pixel_out), 32'(sb_q[0]));
                chk("phase", 32'(phase), 32'(vcnt % 3));
                chk("col", 32'(col), 32'(idx % W));
                chk("row", 32'(row), 32'(idx / W));
                if (vcnt % 3 == 2 && sb_q.size() > 0) void'(sb_q.pop_front());
                vcnt++;
                if (vcnt == NV) exp_fd = 1;
            end else begin
                chk("phase_idle", 32'(phase), 32'd0);
                if (active && !frame_done) begin
                    stall_m++;
                    if (strict && vcnt > 0) chk("contig", 32'(pixel_valid), 32'd1);
                end
            end
            if (frame_done) begin
                chk("valid_total", 32'(vcnt), 32'(NV));
`ifdef FEEDER_STALL_CNT_EN
                chk("stall_count", stall_count, 32'(stall_m));
`endif
                vcnt = 0;
            end
            if (start && !active) begin
                active = 1;
                stall_m = 0;
            end else if (frame_done) begin
                active = 0;
            end
            if (hs) sb_q.push_back(s_pixel);
            prev_v = pixel_valid;
            prev_ph = int'(phase);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pix"}, 32'(pixel_out), 32'd0);
        chk({tag, "_vld"}, 32'(pixel_valid), 32'd0);
        chk({tag, "_ph"}, 32'(phase), 32'd0);
        chk({tag, "_col"}, 32'(col), 32'd0);
        chk({tag, "_row"}, 32'(row), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
        chk({tag, "_rdy"}, 32'(s_ready), 32'd0);
`ifdef FEEDER_STALL_CNT_EN
        chk({tag, "_stall"}, stall_count, 32'd0);
`endif
    endtask

    // rst held across two rising edges; outputs checked while it is still high
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        src_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_after"}, 32'(s_ready), 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2000);
        chk({tag, "_done_seen"}, 32'(frame_done), 32'd1);
    endtask

    task automatic wait_pixel(input string tag, input int c, input int ph);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pixel_valid && int'(col) == c && row == 1'b0 && int'(phase) == ph) && n < 500);
        chk({tag, "_pix_seen"}, 32'(pixel_valid), 32'd1);
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(24'($urandom));
    endtask

    initial begin
        do_reset("rst0");

        // 1: prefill with s_valid held, frame must stream without gaps
        for (int i = 1; i <= 8; i++) src_q.push_back(24'(i));
        repeat (8) @(posedge clk);
        strict = 1;
        pulse_start();
        wait_done("t1");
        strict = 0;

        // 2: fill FIFO in IDLE, fifth pixel must wait
        add_random(5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t2_full_ready", 32'(s_ready), 32'd0);
        chk("t2_pending", 32'(src_q.size()), 32'd1);
        pulse_start();
        add_random(3);
        wait_done("t2");

        // 3: slow source, stalls only between bursts
        feed_gap = 9;
        add_random(8);
        pulse_start();
        wait_done("t3");
        feed_gap = 0;

        // 4: reset in phase 1 of the third pixel, then replay
        add_random(8);
        pulse_start();
        wait_pixel("t4", 2, 1);
        do_reset("t4rst");
        pulse_start();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t4_flushed", 32'(pixel_valid), 32'd0);
        add_random(8);
        wait_done("t4");

        // 5: start while busy is ignored
        rnd_gap = 1;
        add_random(8);
        pulse_start();
        wait_pixel("t5", 1, 0);
        pulse_start();
        wait_done("t5");
        repeat (4) @(negedge clk);
        chk("t5_idle", 32'(busy), 32'd0);
        rnd_gap = 0;

        // 6: push and pop in the same cycle with three entries stored
        do_reset("t6rst");
        add_random(3);
        repeat (6) @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        add_random(5);
        @(posedge clk);
        @(negedge clk);
        chk("t6_pushpop_ready", 32'(s_ready), 32'd1);
        wait_done("t6");

        // 7: random traffic over several frames
        rnd_gap = 1;
        for (int f = 0; f < 3; f++) begin
            add_random(8);
            pulse_start();
            wait_done("t7");
        end
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
